// File: rtl/timer_share_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package     : timer_share_pkg                                    |
// | Description : Shared constants for timer_share_sequencer: timer  |
// |               register map, control bits, FSM state encoding and |
// |               a small period helper.                             |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package timer_share_pkg;

  // Timer register addresses on the slave port
  localparam logic [2:0] c_addr_status   = 3'd0;
  localparam logic [2:0] c_addr_control  = 3'd1;
  localparam logic [2:0] c_addr_period_l = 3'd2;
  localparam logic [2:0] c_addr_period_h = 3'd3;

  // Control register bit positions
  localparam int c_ctrl_ito   = 0;
  localparam int c_ctrl_cont  = 1;
  localparam int c_ctrl_start = 2;
  localparam int c_ctrl_stop  = 3;

  // One-shot start with interrupt enabled, continuous mode left clear
  localparam logic [15:0] c_ctrl_start_word =
    16'((1 << c_ctrl_start) | (1 << c_ctrl_ito) | (0 << c_ctrl_cont));

  // Stop the counter and mask the interrupt in one write
  localparam logic [15:0] c_ctrl_stop_word = 16'(1 << c_ctrl_stop);

  // Sequencer FSM state encoding
  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_wr_pl   = 3'd1;
  localparam logic [2:0] c_st_wr_ph   = 3'd2;
  localparam logic [2:0] c_st_wr_ctrl = 3'd3;
  localparam logic [2:0] c_st_wait    = 3'd4;
  localparam logic [2:0] c_st_stop    = 3'd5;
  localparam logic [2:0] c_st_clr     = 3'd6;
  localparam logic [2:0] c_st_done    = 3'd7;

  // A zero period would never expire on the timer, so it is run as one tick
  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_share_sequencer_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : rr_arbiter                                         |
// | Description : Combinational round-robin pick. Returns the first  |
// |               set request bit at or after the pointer, wrapping  |
// |               modulo N_REQ. The caller registers the result.     |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   pointer,
  output logic             valid,
  output logic [IDW-1:0]   index
);

  int w_pos;

  // Scan from the farthest slot back to the pointer so the nearest requester wins
  always_comb begin
    valid = 1'b0;
    index = '0;
    w_pos = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = int'(pointer) + k;
      if (w_pos >= N_REQ) begin
        w_pos = w_pos - N_REQ;
      end
      if (req[w_pos[IDW-1:0]]) begin
        valid = 1'b1;
        index = w_pos[IDW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/timer_share_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : timer_share_sequencer                              |
// | Description : Shares one high_res_timer between N_REQ one-shot   |
// |               delay requesters. Round-robin grant, then an FSM   |
// |               masters the timer slave port: load period, start,  |
// |               wait for irq, clear status, pulse done to owner.   |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module timer_share_sequencer
  import timer_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [32*N_REQ-1:0] period,
  output logic [N_REQ-1:0]    done,
  output logic                busy,
  output logic [IDW-1:0]      grant_id,
  output logic [2:0]          tmr_address,
  output logic                tmr_chipselect,
  output logic                tmr_write_n,
  output logic [15:0]         tmr_writedata,
  input  logic                tmr_irq
);

  logic [2:0]       r_state;
  logic [2:0]       w_state_next;
  logic [IDW-1:0]   r_grant_id;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   w_ptr_next;
  logic [15:0]      r_period_hi;
  logic             r_cancel;
  logic             w_owner_req;
  logic             w_pick_valid;
  logic [IDW-1:0]   w_pick_index;
  logic [31:0]      w_pick_period;
  logic [31:0]      w_period_arr [N_REQ];

  logic [N_REQ-1:0] w_done;
  logic             w_busy;
  logic             w_cs;
  logic             w_write_n;
  logic [2:0]       w_addr;
  logic [15:0]      w_wdata;

  // Split the flat period bus into one word per requester
  for (genvar i = 0; i < N_REQ; i++) begin : g_period_unpack
    assign w_period_arr[i] = period[32*i +: 32];
  end

  rr_arbiter #(
    .N_REQ   (N_REQ),
    .IDW     (IDW)
  ) u_rr_arbiter (
    .req     (req),
    .pointer (r_rr_ptr),
    .valid   (w_pick_valid),
    .index   (w_pick_index)
  );

  assign w_pick_period = clamp_period(w_period_arr[w_pick_index]);
  assign w_owner_req   = req[r_grant_id];
  assign w_ptr_next    = (r_grant_id == IDW'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;
  assign grant_id      = r_grant_id;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; irq is checked before the cancel so a coincident expiry still completes
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle:    if (w_pick_valid) w_state_next = c_st_wr_pl;
      c_st_wr_pl:   w_state_next = c_st_wr_ph;
      c_st_wr_ph:   w_state_next = c_st_wr_ctrl;
      c_st_wr_ctrl: w_state_next = c_st_wait;
      c_st_wait: begin
        if (tmr_irq) begin
          w_state_next = c_st_clr;
        end else if (!w_owner_req) begin
          w_state_next = c_st_stop;
        end
      end
      c_st_stop:    w_state_next = c_st_clr;
      c_st_clr:     w_state_next = r_cancel ? c_st_idle : c_st_done;
      c_st_done:    w_state_next = c_st_idle;
      default:      w_state_next = c_st_idle;
    endcase
  end

  // Grant capture, cancel tracking and round-robin pointer update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant_id  <= '0;
      r_period_hi <= '0;
      r_cancel    <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      if (r_state == c_st_idle) begin
        r_cancel <= 1'b0;
        if (w_pick_valid) begin
          r_grant_id  <= w_pick_index;
          r_period_hi <= w_pick_period[31:16];
        end
      end
      if (r_state == c_st_wait && w_state_next == c_st_stop) begin
        r_cancel <= 1'b1;
      end
      if (r_state == c_st_done || (r_state == c_st_clr && r_cancel)) begin
        r_rr_ptr <= w_ptr_next;
      end
    end
  end

  // Output decode from the upcoming state so the registered outputs line up with it
  always_comb begin
    w_done    = '0;
    w_busy    = (w_state_next != c_st_idle);
    w_cs      = 1'b0;
    w_write_n = 1'b1;
    w_addr    = c_addr_status;
    w_wdata   = '0;
    case (w_state_next)
      c_st_wr_pl: begin
        // Only entered from IDLE, so the low half comes straight from the pick
        w_cs      = 1'b1;
        w_write_n = 1'b0;
        w_addr    = c_addr_period_l;
        w_wdata   = w_pick_period[15:0];
      end
      c_st_wr_ph: begin
        w_cs      = 1'b1;
        w_write_n = 1'b0;
        w_addr    = c_addr_period_h;
        w_wdata   = r_period_hi;
      end
      c_st_wr_ctrl: begin
        w_cs      = 1'b1;
        w_write_n = 1'b0;
        w_addr    = c_addr_control;
        w_wdata   = c_ctrl_start_word;
      end
      c_st_stop: begin
        w_cs      = 1'b1;
        w_write_n = 1'b0;
        w_addr    = c_addr_control;
        w_wdata   = c_ctrl_stop_word;
      end
      c_st_clr: begin
        w_cs      = 1'b1;
        w_write_n = 1'b0;
        w_addr    = c_addr_status;
        w_wdata   = '0;
      end
      c_st_done: begin
        w_done[r_grant_id] = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done           <= '0;
      busy           <= 1'b0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= '0;
      tmr_writedata  <= '0;
    end else begin
      done           <= w_done;
      busy           <= w_busy;
      tmr_chipselect <= w_cs;
      tmr_write_n    <= w_write_n;
      tmr_address    <= w_addr;
      tmr_writedata  <= w_wdata;
    end
  end

endmodule
`default_nettype wire
